// File: rtl/wb_pwm_timer_regs_if.sv
// rtl/wb_pwm_timer_regs_if.sv - Wishbone classic bus bundle for the PWM/timer register file
interface wb_pwm_timer_regs_if #(
    parameter int DW = 16,
    parameter int AW = 2
);
    logic            i_wb_cyc;
    logic            i_wb_stb;
    logic            i_wb_we;
    logic [AW-1:0]   i_wb_adr;
    logic [DW-1:0]   i_wb_dat;
    logic [DW/8-1:0] i_wb_sel;
    logic [DW-1:0]   o_wb_dat;
    logic            o_wb_ack;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        input  o_wb_dat, o_wb_ack
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
        output o_wb_dat, o_wb_ack
    );
endinterface

// File: rtl/wb_pwm_timer_regs.sv
// rtl/wb_pwm_timer_regs.sv - Wishbone slave holding ctrl/divisor/period/duty registers of the PWM timer
module wb_pwm_timer_regs #(
    parameter int            DW      = 16,
    parameter int            AW      = 2,
    parameter logic [DW-1:0] DIV_RST = 16'd1
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    wb_pwm_timer_regs_if.slave wb,
    input  logic          i_irq_flag,
    output logic [7:0]    o_ctrl,
    output logic [DW-1:0] o_divisor,
    output logic [DW-1:0] o_period,
    output logic [DW-1:0] o_dc,
    output logic          o_irq
);
    localparam logic [AW-1:0] ADR_CTRL = AW'(0);
    localparam logic [AW-1:0] ADR_DIV  = AW'(1);
    localparam logic [AW-1:0] ADR_PER  = AW'(2);
    localparam logic [AW-1:0] ADR_DC   = AW'(3);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_ack;
    logic [DW-1:0] r_rd_data;
    logic [7:0]    r_ctrl;
    logic [DW-1:0] r_divisor;
    logic [DW-1:0] r_period;
    logic [DW-1:0] r_dc;
    logic          r_irq_prev;

    logic          w_access;
    logic          w_wr;
    logic          w_irq_rise;
    logic [7:0]    w_ctrl_next;
    logic [DW-1:0] w_div_next;
    logic [DW-1:0] w_per_next;
    logic [DW-1:0] w_dc_next;
    logic [DW-1:0] w_rd_data;

    // Next-state values for every register: byte-lane merge, irq capture, self-clearing reset bit
    always_comb begin
        w_access   = wb.i_wb_cyc & wb.i_wb_stb & (r_state == IDLE);
        w_wr       = w_access & wb.i_wb_we;
        w_irq_rise = i_irq_flag & ~r_irq_prev;

        w_div_next = r_divisor;
        w_per_next = r_period;
        w_dc_next  = r_dc;
        for (int b = 0; b < DW/8; b++) begin
            if (w_wr && wb.i_wb_sel[b]) begin
                if (wb.i_wb_adr == ADR_DIV) w_div_next[b*8 +: 8] = wb.i_wb_dat[b*8 +: 8];
                if (wb.i_wb_adr == ADR_PER) w_per_next[b*8 +: 8] = wb.i_wb_dat[b*8 +: 8];
                if (wb.i_wb_adr == ADR_DC)  w_dc_next[b*8 +: 8]  = wb.i_wb_dat[b*8 +: 8];
            end
        end

        // Counter-reset bit lives for one cycle only; irq flag can only be cleared by software
        w_ctrl_next    = r_ctrl;
        w_ctrl_next[7] = 1'b0;
        if (w_wr && (wb.i_wb_adr == ADR_CTRL) && wb.i_wb_sel[0]) begin
            w_ctrl_next[4:0] = wb.i_wb_dat[4:0];
            w_ctrl_next[5]   = r_ctrl[5] & wb.i_wb_dat[5];
            w_ctrl_next[6]   = wb.i_wb_dat[6];
            w_ctrl_next[7]   = wb.i_wb_dat[7];
        end
        if (w_irq_rise) w_ctrl_next[5] = 1'b1;

        unique case (wb.i_wb_adr)
            ADR_CTRL: w_rd_data = {{(DW-8){1'b0}}, r_ctrl};
            ADR_DIV:  w_rd_data = r_divisor;
            ADR_PER:  w_rd_data = r_period;
            default:  w_rd_data = r_dc;
        endcase
    end

    // Handshake FSM plus all register state, cleared asynchronously
    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) begin
            r_state    <= IDLE;
            r_ack      <= 1'b0;
            r_rd_data  <= '0;
            r_ctrl     <= '0;
            r_divisor  <= DIV_RST;
            r_period   <= '0;
            r_dc       <= '0;
            r_irq_prev <= 1'b0;
        end else begin
            r_irq_prev <= i_irq_flag;
            r_ctrl     <= w_ctrl_next;
            r_divisor  <= w_div_next;
            r_period   <= w_per_next;
            r_dc       <= w_dc_next;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                        if (!wb.i_wb_we) r_rd_data <= w_rd_data;
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb.o_wb_dat = r_rd_data;
    assign wb.o_wb_ack = r_ack;
    assign o_ctrl      = r_ctrl;
    assign o_divisor   = r_divisor;
    assign o_period    = r_period;
    assign o_dc        = r_dc;
    assign o_irq       = r_ctrl[5] & r_ctrl[6];
endmodule

// File: tb/tb_wb_pwm_timer_regs.sv
// tb/tb_wb_pwm_timer_regs.sv - table-driven and sequence bench for the PWM timer register file
module tb_wb_pwm_timer_regs;
    logic        i_wb_clk = 1'b0;
    logic        i_wb_rst = 1'b0;
    logic        i_irq_flag = 1'b0;
    logic [7:0]  o_ctrl;
    logic [15:0] o_divisor;
    logic [15:0] o_period;
    logic [15:0] o_dc;
    logic        o_irq;

    int n_cmp = 0;
    int n_bad = 0;

    wb_pwm_timer_regs_if #(.DW(16), .AW(2)) bus ();

    wb_pwm_timer_regs #(.DW(16), .AW(2), .DIV_RST(16'd1)) dut (
        .i_wb_clk   (i_wb_clk),
        .i_wb_rst   (i_wb_rst),
        .wb         (bus.slave),
        .i_irq_flag (i_irq_flag),
        .o_ctrl     (o_ctrl),
        .o_divisor  (o_divisor),
        .o_period   (o_period),
        .o_dc       (o_dc),
        .o_irq      (o_irq)
    );

    always #5 i_wb_clk = ~i_wb_clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [15:0] exp_rd;
        logic [7:0]  exp_ctrl;
        logic [15:0] exp_div;
        logic [15:0] exp_per;
        logic [15:0] exp_dc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer; returns read data and o_ctrl as seen on the ack cycle, then checks ack drops
    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, output logic [15:0] rd, output logic [7:0] ctrl_ack);
        bit got;
        got = 0;
        rd = '0;
        ctrl_ack = '0;
        @(negedge i_wb_clk);
        bus.i_wb_cyc = 1'b1;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we  = we;
        bus.i_wb_adr = adr;
        bus.i_wb_dat = dat;
        bus.i_wb_sel = sel;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge i_wb_clk);
            #1;
            if (bus.o_wb_ack) begin
                got = 1;
                rd = bus.o_wb_dat;
                ctrl_ack = o_ctrl;
            end
        end
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
        end else begin
            @(posedge i_wb_clk);
            #1;
            chk("ack_one_cycle", {31'd0, bus.o_wb_ack}, 32'd0);
        end
    endtask

    logic [15:0] rd;
    logic [7:0]  cack;
    int          acks;

    initial begin
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_adr = '0;
        bus.i_wb_dat = '0;
        bus.i_wb_sel = '0;

        //        we    adr   dat       sel    rd        ctrl   div       per       dc
        vecs[0]  = '{1'b0, 2'd1, 16'h0000, 2'b11, 16'h0001, 8'h00, 16'h0001, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 2'd2, 16'h1234, 2'b11, 16'h0000, 8'h00, 16'h0001, 16'h1234, 16'h0000};
        vecs[2]  = '{1'b0, 2'd2, 16'h0000, 2'b11, 16'h1234, 8'h00, 16'h0001, 16'h1234, 16'h0000};
        vecs[3]  = '{1'b1, 2'd2, 16'hABCD, 2'b01, 16'h0000, 8'h00, 16'h0001, 16'h12CD, 16'h0000};
        vecs[4]  = '{1'b1, 2'd2, 16'hABCD, 2'b10, 16'h0000, 8'h00, 16'h0001, 16'hABCD, 16'h0000};
        vecs[5]  = '{1'b1, 2'd1, 16'h5A5A, 2'b11, 16'h0000, 8'h00, 16'h5A5A, 16'hABCD, 16'h0000};
        vecs[6]  = '{1'b1, 2'd3, 16'hFF00, 2'b10, 16'h0000, 8'h00, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[7]  = '{1'b1, 2'd0, 16'hFF3F, 2'b11, 16'h0000, 8'h1F, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[8]  = '{1'b0, 2'd0, 16'h0000, 2'b11, 16'h001F, 8'h1F, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[9]  = '{1'b1, 2'd0, 16'h0055, 2'b10, 16'h0000, 8'h1F, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[10] = '{1'b0, 2'd3, 16'h0000, 2'b00, 16'hFF00, 8'h1F, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[11] = '{1'b0, 2'd1, 16'h0000, 2'b00, 16'h5A5A, 8'h1F, 16'h5A5A, 16'hABCD, 16'hFF00};
        vecs[12] = '{1'b1, 2'd0, 16'h0000, 2'b01, 16'h0000, 8'h00, 16'h5A5A, 16'hABCD, 16'hFF00};

        repeat (2) @(posedge i_wb_clk);
        #1;
        chk("rst_ctrl", {24'd0, o_ctrl}, 32'h0);
        chk("rst_div", {16'd0, o_divisor}, 32'h1);
        chk("rst_ack", {31'd0, bus.o_wb_ack}, 32'h0);
        i_wb_rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, cack);
            if (!vecs[i].we) chk($sformatf("v%0d_rd", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
            chk($sformatf("v%0d_ctrl", i), {24'd0, o_ctrl}, {24'd0, vecs[i].exp_ctrl});
            chk($sformatf("v%0d_div", i), {16'd0, o_divisor}, {16'd0, vecs[i].exp_div});
            chk($sformatf("v%0d_per", i), {16'd0, o_period}, {16'd0, vecs[i].exp_per});
            chk($sformatf("v%0d_dc", i), {16'd0, o_dc}, {16'd0, vecs[i].exp_dc});
            chk($sformatf("v%0d_irq", i), {31'd0, o_irq}, 32'd0);
        end

        // Interrupt capture and software clear
        wb_xfer(1'b1, 2'd0, 16'h0040, 2'b01, rd, cack);
        @(negedge i_wb_clk);
        i_irq_flag = 1'b1;
        @(negedge i_wb_clk);
        i_irq_flag = 1'b0;
        @(posedge i_wb_clk);
        #1;
        chk("irq_set_ctrl", {24'd0, o_ctrl}, 32'h60);
        chk("irq_set_line", {31'd0, o_irq}, 32'd1);
        wb_xfer(1'b1, 2'd0, 16'h0040, 2'b01, rd, cack);
        chk("irq_clr_ctrl", {24'd0, o_ctrl}, 32'h40);
        chk("irq_clr_line", {31'd0, o_irq}, 32'd0);
        // Rising flag lands on the same edge as the clearing write: set wins
        i_irq_flag = 1'b1;
        wb_xfer(1'b1, 2'd0, 16'h0040, 2'b01, rd, cack);
        chk("irq_race_ctrl", {24'd0, cack}, 32'h60);
        chk("irq_race_line", {31'd0, o_irq}, 32'd1);
        i_irq_flag = 1'b0;

        // Counter-reset bit self-clears after one cycle
        wb_xfer(1'b1, 2'd0, 16'h0084, 2'b01, rd, cack);
        chk("selfclr_ack", {24'd0, cack}, 32'h84);
        chk("selfclr_after", {24'd0, o_ctrl}, 32'h04);
        wb_xfer(1'b0, 2'd0, 16'h0000, 2'b00, rd, cack);
        chk("selfclr_read", {16'd0, rd}, 32'h0004);

        // Held strobe: acks on alternate cycles
        acks = 0;
        @(negedge i_wb_clk);
        bus.i_wb_cyc = 1'b1;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_adr = 2'd2;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_wb_clk);
            #1;
            if (bus.o_wb_ack) acks++;
            chk($sformatf("held_ack%0d", c), {31'd0, bus.o_wb_ack}, (c % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        chk("held_count", acks, 3);
        chk("held_rd", {16'd0, bus.o_wb_dat}, 32'hABCD);

        // Reset in the middle of an acknowledged write
        @(negedge i_wb_clk);
        bus.i_wb_cyc = 1'b1;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we  = 1'b1;
        bus.i_wb_adr = 2'd3;
        bus.i_wb_dat = 16'h00AA;
        bus.i_wb_sel = 2'b01;
        @(posedge i_wb_clk);
        #1;
        chk("mid_ack_pre", {31'd0, bus.o_wb_ack}, 32'd1);
        #1;
        i_wb_rst = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, bus.o_wb_ack}, 32'd0);
        chk("mid_rst_ctrl", {24'd0, o_ctrl}, 32'h0);
        chk("mid_rst_div", {16'd0, o_divisor}, 32'h1);
        chk("mid_rst_per", {16'd0, o_period}, 32'h0);
        chk("mid_rst_dc", {16'd0, o_dc}, 32'h0);
        chk("mid_rst_dat", {16'd0, bus.o_wb_dat}, 32'h0);
        chk("mid_rst_irq", {31'd0, o_irq}, 32'd0);
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        @(negedge i_wb_clk);
        i_wb_rst = 1'b1;
        wb_xfer(1'b0, 2'd1, 16'h0000, 2'b00, rd, cack);
        chk("post_rst_rd", {16'd0, rd}, 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
